// File: rtl/axi_rd_pkg.sv
// axi_rd_pkg: shared types and constants for the AXI4-Lite block read master.
// Holds the FSM state encoding and AXI read-response decoding.
package axi_rd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        AR,
        R,
        DONE
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic logic resp_is_err(input logic [1:0] resp);
        logic err;
        unique case (resp)
            RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
            RESP_SLVERR, RESP_DECERR: err = 1'b1;
            default:                  err = 1'b0;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/axi_read_block.sv
// axi_read_block: single-beat AXI4-Lite read master, memory to FIFO.
// Define AXI_READ_RESP_CHECK_EN to abort on SLVERR/DECERR and raise error.
module axi_read_block
    import axi_rd_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SIZE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [SIZE_WIDTH-1:0] transfer_size,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  wr_en,
    input  logic                  full,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // One extra bit so a 0xFFFF byte count still yields 16384 words
    localparam int CW = SIZE_WIDTH + 1;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] words;
    logic [CW-1:0] idx;
    logic [CW-1:0] start_words;
    logic          r_hs;
    logic          last;
    logic          resp_bad;
    logic          unused_bits;

    assign start_words = ({1'b0, transfer_size} + CW'(3)) >> 2;
    assign r_hs        = rvalid && rready;
    assign last        = (idx + CW'(1)) == words;
    assign unused_bits = ^addr[1:0];

`ifdef AXI_READ_RESP_CHECK_EN
    logic err_q;

    assign resp_bad = resp_is_err(rresp);
    assign error    = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state == IDLE && start) begin
            err_q <= 1'b0;
        end else if (r_hs && resp_bad) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_resp;

    assign unused_resp = resp_is_err(rresp);
    assign resp_bad    = 1'b0;
    assign error       = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (start_words == '0) ? DONE : AR;
                end
            end
            AR: begin
                if (arready) begin
                    state_nx = R;
                end
            end
            R: begin
                if (r_hs) begin
                    state_nx = (last || resp_bad) ? DONE : AR;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        arvalid = 1'b0;
        rready  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state)
            AR: begin
                arvalid = 1'b1;
                busy    = 1'b1;
            end
            R: begin
                rready = !full;
                busy   = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign wr_en    = r_hs && !resp_bad;
    assign data_out = rdata;

    // araddr tracks base + 4*idx; it only moves on an R handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            araddr <= '0;
            words  <= '0;
            idx    <= '0;
        end else if (state == IDLE && start) begin
            araddr <= {addr[ADDR_WIDTH-1:2], 2'b00};
            words  <= start_words;
            idx    <= '0;
        end else if (r_hs) begin
            araddr <= araddr + ADDR_WIDTH'(4);
            idx    <= idx + CW'(1);
        end
    end

endmodule

// File: tb/tb_axi_read_block.sv
// tb_axi_read_block: randomized AXI slave plus queue-based FIFO-side model.
// Build with AXI_READ_RESP_CHECK_EN to also check the error-abort path.
`timescale 1ns/1ps
module tb_axi_read_block;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] addr = '0;
    logic [15:0] transfer_size = '0;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] data_out;
    logic        wr_en;
    logic        full = 1'b0;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    axi_read_block dut (
        .clk(clk), .reset(reset), .start(start), .addr(addr),
        .transfer_size(transfer_size), .araddr(araddr),
        .arvalid(arvalid), .arready(arready), .rdata(rdata),
        .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .data_out(data_out), .wr_en(wr_en), .full(full),
        .busy(busy), .done(done), .error(error)
    );

    int errors = 0;
    int checks = 0;
    int unsigned cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    bit rand_mode = 1'b0;
    int full_beat = -1;
    int err_beat = -1;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] ar_log[$];
    logic [31:0] push_log[$];
    int stall_cnt = 0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E3779B1) ^ 32'h5BD1E995;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] got);
        checks++;
        errors++;
        $display("FAIL %s: got %h, required nothing here", name, got);
    endtask

    // AXI slave: random arready, random read latency, random FIFO full
    initial begin : slave
        bit          ar_hs, r_hs, st, pend;
        logic [31:0] paddr;
        int          dly, beat, hold;
        pend = 0; dly = 0; beat = 0; hold = 0; paddr = '0;
        forever begin
            @(negedge clk);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            st    = start && !busy && !done;
            if (ar_hs) paddr = araddr;
            @(posedge clk);
            #1;
            if (reset) begin
                pend = 0; rvalid = 0; hold = 0;
                full = 0; arready = 0; beat = 0;
                continue;
            end
            if (st) beat = 0;
            if (r_hs) begin
                rvalid = 0;
                pend = 0;
            end
            if (ar_hs) begin
                pend = 1;
                dly = rand_mode ? $urandom_range(0, 3) : 0;
            end
            if (pend && !rvalid) begin
                if (dly == 0) begin
                    rvalid = 1;
                    rdata = mem_rd(paddr);
                    if (beat == err_beat)
                        rresp = rand_mode ? {1'b1, 1'($urandom_range(0, 1))} : 2'b10;
                    else
                        rresp = rand_mode ? {1'b0, 1'($urandom_range(0, 1))} : 2'b00;
                    if (beat == full_beat) hold = 5;
                    beat++;
                end else begin
                    dly--;
                end
            end
            if (hold > 0) begin
                full = 1;
                hold--;
            end else begin
                full = rand_mode ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            arready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Model: expected address/data queues built from each accepted start
    initial begin : compare
        logic [31:0] exp_ar[$];
        logic [31:0] exp_d[$];
        logic [31:0] base;
        bit active, was_active, outst, m_err, exp_err, err_now;
        bit ar_hs, r_hs;
        int words, n_push, n_ar;
        active = 0; outst = 0; m_err = 0; exp_err = 0;
        forever begin
            @(negedge clk);
            chk("data_out", data_out, rdata);
            chk("error", error, m_err);
            if (reset) begin
                chk("rst_araddr", araddr, 32'h0);
                chk("rst_ctrl", {arvalid, rready, wr_en, busy, done}, 32'h0);
                exp_ar.delete();
                exp_d.delete();
                active = 0; outst = 0; m_err = 0; exp_err = 0;
                continue;
            end
            was_active = active;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            chk("busy", busy, active && !done);
            if (arvalid) begin
                chk("ar_outstanding", outst, 0);
                if (exp_ar.size() == 0) fail("ar_unexpected", araddr);
                else chk("araddr", araddr, exp_ar[0]);
                if (ar_hs) begin
                    if (exp_ar.size() != 0) void'(exp_ar.pop_front());
                    ar_log.push_back(araddr);
                    outst = 1;
                end
            end
            if (full) chk("rready_full", rready, 0);
            if (busy && !arvalid) chk("rready", rready, !full);
            if (rvalid && !rready) stall_cnt++;
            err_now = exp_err && exp_d.size() == 0;
            chk("wr_en", wr_en, r_hs && !err_now);
            if (wr_en) begin
                push_log.push_back(data_out);
                if (exp_d.size() == 0) fail("push_unexpected", data_out);
                else chk("push_data", data_out, exp_d.pop_front());
            end
            if (r_hs) begin
                outst = 0;
                if (err_now) m_err = 1;
            end
            if (done) begin
                if (!active) fail("done_unexpected", done);
                chk("done_busy", busy, 0);
                chk("done_ar_left", exp_ar.size(), 0);
                chk("done_push_left", exp_d.size(), 0);
                active = 0;
            end
            if (start && !was_active) begin
                words = (int'(transfer_size) + 3) / 4;
                n_push = words;
                n_ar = words;
                exp_err = 0;
`ifdef AXI_READ_RESP_CHECK_EN
                if (err_beat >= 0 && err_beat < words) begin
                    n_push = err_beat;
                    n_ar = err_beat + 1;
                    exp_err = 1;
                end
`endif
                base = {addr[31:2], 2'b00};
                exp_ar.delete();
                exp_d.delete();
                for (int k = 0; k < n_ar; k++)
                    exp_ar.push_back(base + 32'(4 * k));
                for (int k = 0; k < n_push; k++)
                    exp_d.push_back(mem_rd(base + 32'(4 * k)));
                m_err = 0;
                active = 1;
            end
        end
    end

    // n = cycle index of done relative to the start edge (start edge = N)
    task automatic run(input logic [31:0] a, input logic [15:0] s,
                       input bit spur, output int n, output logic [1:0] first);
        int unsigned c0;
        @(posedge clk);
        #1;
        start = 1; addr = a; transfer_size = s;
        @(posedge clk);
        #1;
        c0 = cycle;
        start = 0;
        if (spur && s != 0) begin
            start = 1; addr = ~a; transfer_size = s + 16'd8;
            @(posedge clk);
            #1;
            start = 0;
        end
        n = 0;
        first = 2'b00;
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk);
            if (i == 0) first = {arvalid, busy};
            if (done) begin
                n = int'(cycle - c0) + 1;
                break;
            end
        end
        if (n == 0) fail("done_timeout", 32'(s));
    endtask

    initial begin : main
        int n, a0, p0, s0;
        logic [1:0] first;
        logic [31:0] a;
        logic [15:0] s;
        bit found;
        logic [31:0] e_addr[4];
        logic [31:0] e_dat[4];
        int sz[4];
        int cy[4];

        mem[32'h1000] = 32'hDEADBEEF;
        mem[32'h1004] = 32'h12345678;
        mem[32'h1008] = 32'hA5A5A5A5;
        mem[32'h100C] = 32'h00000000;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 0;

        // Zero-wait four-word read
        a0 = ar_log.size(); p0 = push_log.size();
        run(32'h1000, 16'd16, 0, n, first);
        chk("t1_done_cycle", n, 9);
        chk("t1_first_cycle", first, 2'b11);
        chk("t1_ar_count", ar_log.size() - a0, 4);
        chk("t1_push_count", push_log.size() - p0, 4);
        e_addr = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        e_dat  = '{32'hDEADBEEF, 32'h12345678, 32'hA5A5A5A5, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            if (ar_log.size() > a0 + i) chk("t1_araddr", ar_log[a0 + i], e_addr[i]);
            if (push_log.size() > p0 + i) chk("t1_data", push_log[p0 + i], e_dat[i]);
        end
        chk("t1_error", error, 0);

        // Unaligned start, partial last word
        a0 = ar_log.size();
        run(32'h2003, 16'd5, 0, n, first);
        chk("t2_done_cycle", n, 5);
        chk("t2_ar_count", ar_log.size() - a0, 2);
        if (ar_log.size() >= a0 + 2) begin
            chk("t2_addr0", ar_log[a0], 32'h2000);
            chk("t2_addr1", ar_log[a0 + 1], 32'h2004);
        end

        // Zero-length transfer
        a0 = ar_log.size();
        run(32'h2100, 16'd0, 0, n, first);
        chk("t3_done_cycle", n, 1);
        chk("t3_first", first, 2'b00);
        chk("t3_ar_count", ar_log.size() - a0, 0);

        // Byte counts around word boundaries
        sz = '{1, 4, 7, 8};
        cy = '{3, 3, 5, 5};
        for (int i = 0; i < 4; i++) begin
            run(32'h2200, 16'(sz[i]), 0, n, first);
            chk("t4_done_cycle", n, cy[i]);
        end

        // FIFO full for 5 cycles on the second beat
        full_beat = 1;
        p0 = push_log.size(); s0 = stall_cnt;
        run(32'h3000, 16'd16, 0, n, first);
        full_beat = -1;
        chk("t5_done_cycle", n, 14);
        chk("t5_stall", stall_cnt - s0, 5);
        chk("t5_push_count", push_log.size() - p0, 4);
        for (int i = 0; i < 4; i++)
            if (push_log.size() > p0 + i)
                chk("t5_data", push_log[p0 + i], mem_rd(32'h3000 + 32'(4 * i)));

        // Address wrap
        a0 = ar_log.size();
        run(32'hFFFFFFF8, 16'd16, 0, n, first);
        e_addr = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
        chk("t6_ar_count", ar_log.size() - a0, 4);
        for (int i = 0; i < 4; i++)
            if (ar_log.size() > a0 + i) chk("t6_araddr", ar_log[a0 + i], e_addr[i]);

        // Largest byte count
        a0 = ar_log.size();
        run(32'h0001_0000, 16'hFFFF, 0, n, first);
        chk("t7_done_cycle", n, 32769);
        chk("t7_ar_count", ar_log.size() - a0, 16384);

        // Error response on word 2
        err_beat = 1;
        p0 = push_log.size(); a0 = ar_log.size();
        run(32'h4000, 16'd16, 0, n, first);
        err_beat = -1;
`ifdef AXI_READ_RESP_CHECK_EN
        chk("t8_done_cycle", n, 5);
        chk("t8_push_count", push_log.size() - p0, 1);
        chk("t8_ar_count", ar_log.size() - a0, 2);
        chk("t8_error", error, 1);
        @(negedge clk);
        chk("t8_error_hold", error, 1);
`else
        chk("t8_done_cycle", n, 9);
        chk("t8_push_count", push_log.size() - p0, 4);
        chk("t8_error", error, 0);
`endif

        // Reset in the middle of an R beat
        @(posedge clk);
        #1;
        start = 1; addr = 32'h5000; transfer_size = 16'd16;
        @(posedge clk);
        #1;
        start = 0;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rvalid && busy && !arvalid) begin
                found = 1;
                break;
            end
        end
        chk("t9_found_r", found, 1);
        #2;
        reset = 1;
        #1;
        chk("t9_mid_reset", {arvalid, rready, busy, wr_en}, 4'b0000);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 0;

        // Random traffic, random stalls, stray starts, random error beats
        rand_mode = 1;
        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            if ($urandom_range(0, 9) == 0) s = 16'($urandom_range(0, 3));
            else s = 16'($urandom_range(0, 80));
            err_beat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1;
            run(a, s, ($urandom_range(0, 3) == 0), n, first);
        end
        err_beat = -1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
